// File: rtl/hex_seg_dimmer.sv
// Seven-segment output stage: frame-synchronised digit latch,
// global PWM dimming and per-digit blinking behind an Avalon-MM slave.
module hex_seg_dimmer #(
    parameter int NUM_DIGITS = 6,
    parameter int PWM_DIV    = 196
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    input  logic [8*NUM_DIGITS-1:0] seg_in,
    output logic [8*NUM_DIGITS-1:0] seg_out,
    output logic                    frame_tick
);

    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int SW = 8 * NUM_DIGITS;

    logic [PW-1:0]         pre_cnt;
    logic [7:0]            pwm_cnt;
    logic [7:0]            bright;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic [7:0]            blink_half;
    logic [7:0]            blink_cnt;
    logic                  blink_phase;
    logic [SW-1:0]         shadow;
    logic [SW-1:0]         seg_next;

    logic wr;
    logic step;
    logic frame;
    logic lit;
    logic unused_wdata;

    assign wr    = chipselect && !write_n;
    assign step  = (pre_cnt == PW'(PWM_DIV - 1));
    assign frame = step && (pwm_cnt == 8'hFF);
    assign lit   = (bright == 8'hFF) || (pwm_cnt < bright);

    assign frame_tick   = frame;
    assign unused_wdata = ^writedata[31:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= step ? '0 : pre_cnt + 1'b1;
            if (step)
                pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bright     <= 8'hFF;
            blink_mask <= '0;
            blink_half <= 8'd250;
        end else if (wr) begin
            case (address)
                2'd0:    bright     <= writedata[7:0];
                2'd1:    blink_mask <= writedata[NUM_DIGITS-1:0];
                2'd2:    blink_half <= writedata[7:0];
                default: ;
            endcase
        end
    end

    // A BLINK_HALF write restarts the blink cycle and beats a same-cycle frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (wr && address == 2'd2) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame) begin
            if (blink_half == 8'd0) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (blink_cnt == blink_half - 8'd1) begin
                blink_cnt   <= '0;
                blink_phase <= !blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            shadow <= '1;
        else if (frame)
            shadow <= seg_in;
    end

    always_comb begin
        seg_next = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (lit && !(blink_mask[k] && !blink_phase))
                seg_next[8*k +: 8] = shadow[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            seg_out <= '1;
        else
            seg_out <= seg_next;
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = {24'd0, bright};
            2'd1:    readdata = 32'(blink_mask);
            2'd2:    readdata = {24'd0, blink_half};
            default: readdata = {16'd0, pwm_cnt, 7'd0, blink_phase};
        endcase
    end

endmodule

// File: tb/tb_hex_seg_dimmer.sv
// Directed bench for hex_seg_dimmer with a short PWM prescaler.
module tb_hex_seg_dimmer;

    localparam int ND    = 6;
    localparam int PD    = 2;
    localparam int FRAME = 256 * PD;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [8*ND-1:0] seg_in;
    logic [8*ND-1:0] seg_out;
    logic          frame_tick;

    int checks = 0;
    int errors = 0;

    logic [47:0] sh_exp;
    logic [5:0]  mask_m;
    logic [7:0]  half_m;
    logic [7:0]  cnt_m;
    logic        phase_m;
    logic [31:0] rv;
    int          n;
    int          cyc;
    int          bad;
    int          on_cnt;
    int          off_cnt;

    hex_seg_dimmer #(.NUM_DIGITS(ND), .PWM_DIV(PD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .seg_in     (seg_in),
        .seg_out    (seg_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wait_frame(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!frame_tick && cnt < FRAME + 50);
        check("frame_timeout", frame_tick, 1'b1);
    endtask

    function automatic logic [47:0] exp_seg(input logic [47:0] sh,
                                            input logic [5:0] m,
                                            input logic ph);
        logic [47:0] r;
        r = sh;
        for (int d = 0; d < ND; d++)
            if (m[d] && !ph) r[8*d +: 8] = 8'hFF;
        return r;
    endfunction

    // Blink model, stepped once per observed frame.
    task automatic blink_step();
        if (half_m == 8'd0) begin
            cnt_m   = 8'd0;
            phase_m = 1'b1;
        end else if (cnt_m == half_m - 8'd1) begin
            cnt_m   = 8'd0;
            phase_m = !phase_m;
        end else begin
            cnt_m = cnt_m + 8'd1;
        end
    endtask

    task automatic frame_and_check(input string tag);
        int c;
        wait_frame(c);
        blink_step();
        @(negedge clk);
        @(negedge clk);
        rd(2'd3, rv);
        check({tag, "_phase"}, rv[0], phase_m);
        check({tag, "_seg"}, seg_out, exp_seg(sh_exp, mask_m, phase_m));
    endtask

    initial begin
        seg_in = {6{8'h86}};
        sh_exp = {6{8'h86}};
        mask_m = '0;
        half_m = 8'd250;
        cnt_m  = '0;
        phase_m = 1'b1;

        #23;
        rd(2'd0, rv); check("rst_bright", rv, 32'h0000_00FF);
        rd(2'd1, rv); check("rst_mask", rv, 32'h0000_0000);
        rd(2'd2, rv); check("rst_half", rv, 32'h0000_00FA);
        rd(2'd3, rv); check("rst_status", rv, 32'h0000_0001);
        check("rst_seg", seg_out, {6{8'hFF}});
        check("rst_tick", frame_tick, 1'b0);

        @(negedge clk);
        reset_n = 1'b1;
        cyc = 1;
        bad = 0;
        while (!frame_tick && cyc < FRAME + 50) begin
            if (seg_out !== {6{8'hFF}}) bad++;
            @(negedge clk);
            cyc++;
        end
        check("first_frame_cycle", cyc, FRAME);
        check("blank_before_frame", bad, 0);
        @(negedge clk);
        @(negedge clk);
        bad = 0;
        repeat (100) begin
            if (seg_out !== sh_exp) bad++;
            @(negedge clk);
        end
        check("lit_after_frame", bad, 0);

        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, rv); check("status_ro_phase", rv[0], 1'b1);
        rd(2'd0, rv); check("status_wr_bright", rv, 32'h0000_00FF);
        rd(2'd2, rv); check("status_wr_half", rv, 32'h0000_00FA);

        seg_in[23:16] = 8'hC0;
        repeat (10) @(negedge clk);
        check("digit2_hold", seg_out, sh_exp);
        wait_frame(n);
        sh_exp = 48'h8686_86C0_8686;
        @(negedge clk);
        @(negedge clk);
        check("digit2_update", seg_out, sh_exp);

        wr(2'd0, 32'd64);
        rd(2'd0, rv); check("bright_rb", rv, 32'h0000_0040);
        wait_frame(n);
        on_cnt = 0;
        off_cnt = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (seg_out === sh_exp) on_cnt++;
            if (seg_out === {6{8'hFF}}) off_cnt++;
        end
        check("bright64_on", on_cnt, 128);
        check("bright64_off", off_cnt, 384);

        wr(2'd0, 32'd0);
        wait_frame(n);
        on_cnt = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (seg_out !== {6{8'hFF}}) on_cnt++;
        end
        check("bright0_dark", on_cnt, 0);
        wr(2'd0, 32'd255);

        wait_frame(n);
        wr(2'd1, 32'h05);
        wr(2'd2, 32'd3);
        mask_m  = 6'b000101;
        half_m  = 8'd3;
        cnt_m   = 8'd0;
        phase_m = 1'b1;
        for (int i = 0; i < 9; i++)
            frame_and_check("blink3");

        wr(2'd2, 32'd0);
        half_m  = 8'd0;
        cnt_m   = 8'd0;
        phase_m = 1'b1;
        rd(2'd3, rv); check("half0_phase", rv[0], 1'b1);
        for (int i = 0; i < 3; i++)
            frame_and_check("half0");

        wr(2'd2, 32'd3);
        half_m  = 8'd3;
        cnt_m   = 8'd0;
        phase_m = 1'b1;
        frame_and_check("pre_coinc");
        wait_frame(n);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd2;
        writedata  = 32'd3;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        cnt_m   = 8'd0;
        phase_m = 1'b1;
        rd(2'd2, rv); check("coinc_half", rv, 32'h0000_0003);
        rd(2'd3, rv); check("coinc_phase", rv[0], 1'b1);
        for (int i = 0; i < 3; i++)
            frame_and_check("coinc");

        repeat (37) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_seg", seg_out, {6{8'hFF}});
        rd(2'd3, rv); check("async_rst_status", rv, 32'h0000_0001);
        rd(2'd1, rv); check("async_rst_mask", rv, 32'h0000_0000);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
